// File: rtl/bp_update_ctrl.sv
// Branch-resolution sequencer: flags mispredicts with a registered fetch redirect,
// queues every accepted resolution for the predictor update port, and counts branches/mispredicts.
module bp_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        res_valid,
    output logic        res_ready,
    input  logic [15:0] res_pc,
    input  logic        res_taken,
    input  logic [15:0] res_target,
    input  logic        res_pred_taken,
    input  logic [15:0] res_pred_target,

    input  logic        upd_hold,
    output logic        upd_en,
    output logic [15:0] upd_pc,
    output logic        upd_taken,
    output logic [15:0] upd_target,

    output logic        redirect_valid,
    output logic [15:0] redirect_pc,

    input  logic        stat_clear,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispred
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] STAT_MAX   = 16'hFFFF;

    // FIFO storage; the head is read combinationally so the predictor sees it in the same cycle.
    logic [15:0] pc_mem_q     [DEPTH];
    logic        taken_mem_q  [DEPTH];
    logic [15:0] target_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          redirect_valid_q, redirect_valid_d;
    logic [15:0]   redirect_pc_q,    redirect_pc_d;

    logic [15:0]   stat_branches_q,  stat_branches_d;
    logic [15:0]   stat_mispred_q,   stat_mispred_d;

    logic          accept;
    logic          drain;
    logic          mispredict;
    logic [15:0]   correct_pc;

    assign res_ready = (count_q != FULL_COUNT);
    assign accept    = res_valid && res_ready;
    assign drain     = (count_q != '0) && !upd_hold;

    // A taken branch with the right direction can still miss on the target.
    assign mispredict = (res_taken != res_pred_taken)
                     || (res_taken && (res_pred_target != res_target));
    assign correct_pc = res_taken ? res_target : (res_pc + 16'd2);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        redirect_valid_d = accept && mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (accept && mispredict) begin
            redirect_pc_d = correct_pc;
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at the maximum.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (stat_clear) begin
            stat_branches_d = '0;
            stat_mispred_d  = '0;
        end else begin
            if (accept && (stat_branches_q != STAT_MAX)) begin
                stat_branches_d = stat_branches_q + 16'd1;
            end
            if (accept && mispredict && (stat_mispred_q != STAT_MAX)) begin
                stat_mispred_d = stat_mispred_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 16'h0000;
            stat_branches_q  <= 16'h0000;
            stat_mispred_q   <= 16'h0000;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stat_branches_q  <= stat_branches_d;
            stat_mispred_q   <= stat_mispred_d;
        end
    end

    // Storage needs no reset: entries are only visible while count says they are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem_q[wr_ptr_q]     <= res_pc;
            taken_mem_q[wr_ptr_q]  <= res_taken;
            target_mem_q[wr_ptr_q] <= res_target;
        end
    end

    assign upd_en         = drain;
    assign upd_pc         = pc_mem_q[rd_ptr_q];
    assign upd_taken      = taken_mem_q[rd_ptr_q];
    assign upd_target     = target_mem_q[rd_ptr_q];

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stat_branches  = stat_branches_q;
    assign stat_mispred   = stat_mispred_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a behavioural model queues expected updates,
// redirects and counter values; a negedge monitor compares everything the DUT shows.
module tb_bp_update_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_pc;
    logic        res_taken;
    logic [15:0] res_target;
    logic        res_pred_taken;
    logic [15:0] res_pred_target;
    logic        upd_hold;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        stat_clear;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    always #5 clk = ~clk;

    bp_update_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .upd_hold(upd_hold), .upd_en(upd_en),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stat_clear(stat_clear),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic        taken;
        logic [15:0] target;
    } upd_t;

    upd_t        exp_q[$];
    int          m_count   = 0;
    bit          m_accept  = 0;
    bit          exp_rv    = 0;
    logic [15:0] exp_rpc   = 16'h0000;
    int          exp_br    = 0;
    int          exp_mp    = 0;
    int          total     = 0;
    int          bad       = 0;
    int          upd_seen  = 0;
    bit          started   = 0;
    bit          verbose   = 1;
    bit          rand_hold = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, ordering, redirect and counters from the rules alone.
    always @(posedge clk) begin
        bit          acc;
        bit          pop;
        bit          mp;
        logic [15:0] cpc;
        if (rst) begin
            m_count  = 0;
            exp_q.delete();
            exp_rv   = 0;
            exp_rpc  = 16'h0000;
            exp_br   = 0;
            exp_mp   = 0;
            m_accept = 0;
        end else begin
            acc = res_valid && (m_count < DEPTH);
            pop = (m_count > 0) && !upd_hold;
            mp  = (res_taken != res_pred_taken) || (res_taken && res_pred_target != res_target);
            cpc = res_taken ? res_target : 16'(res_pc + 16'd2);
            if (acc) exp_q.push_back('{pc: res_pc, taken: res_taken, target: res_target});
            exp_rv = acc && mp;
            if (acc && mp) exp_rpc = cpc;
            if (stat_clear) begin
                exp_br = 0;
                exp_mp = 0;
            end else begin
                if (acc && exp_br < 65535) exp_br++;
                if (acc && mp && exp_mp < 65535) exp_mp++;
            end
            m_count  = m_count + int'(acc) - int'(pop);
            m_accept = acc;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes an update.
    always @(negedge clk) begin
        upd_t e;
        if (started) begin
            chk("res_ready", {31'd0, res_ready}, {31'd0, m_count < DEPTH});
            chk("upd_en", {31'd0, upd_en}, {31'd0, (m_count > 0) && !upd_hold});
            if (upd_en) begin
                if (exp_q.size() == 0) begin
                    chk("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    upd_seen++;
                    chk("upd_pc", {16'd0, upd_pc}, {16'd0, e.pc});
                    chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
                    chk("upd_target", {16'd0, upd_target}, {16'd0, e.target});
                    if (verbose)
                        $display("upd #%0d pc=%h taken=%0d target=%h (expected pc=%h taken=%0d target=%h)",
                                 upd_seen, upd_pc, upd_taken, upd_target, e.pc, e.taken, e.target);
                end
            end
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
            chk("redirect_pc", {16'd0, redirect_pc}, {16'd0, exp_rpc});
            chk("stat_branches", {16'd0, stat_branches}, 32'(exp_br));
            chk("stat_mispred", {16'd0, stat_mispred}, 32'(exp_mp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_hold) upd_hold = ($urandom_range(0, 2) == 0);
    endtask

    task automatic idle(input int n);
        res_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [15:0] pc, input logic tk, input logic [15:0] tg,
                        input logic ptk, input logic [15:0] ptg);
        bit got;
        got             = 0;
        res_valid       = 1'b1;
        res_pc          = pc;
        res_taken       = tk;
        res_target      = tg;
        res_pred_taken  = ptk;
        res_pred_target = ptg;
        for (int c = 0; c < 200; c++) begin
            step();
            if (m_accept) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        res_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [15:0] pc;
        logic [15:0] tg;
        logic [15:0] ptg;
        pc  = 16'($urandom) & 16'hFFFE;
        tg  = 16'($urandom) & 16'hFFFE;
        ptg = ($urandom_range(0, 1) == 0) ? tg : (16'($urandom) & 16'hFFFE);
        send(pc, 1'($urandom_range(0, 1)), tg, 1'($urandom_range(0, 1)), ptg);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b1; res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
        res_pred_taken = 1'b0; res_pred_target = '0; upd_hold = 1'b0; stat_clear = 1'b0;
        @(posedge clk); #1;
        started = 1;
        step();
        rst = 1'b0;
        chk("reset_ready", {31'd0, res_ready}, 32'd1);
        chk("reset_upd_en", {31'd0, upd_en}, 32'd0);

        // Correctly predicted taken branch
        send(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        chk("t1_no_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("t1_upd_en", {31'd0, upd_en}, 32'd1);
        chk("t1_upd_pc", {16'd0, upd_pc}, 32'h0010);
        chk("t1_branches", {16'd0, stat_branches}, 32'd1);
        idle(2);

        // Direction mispredict, fall-through target
        send(16'h0020, 1'b0, 16'h0000, 1'b1, 16'h0000);
        chk("t2_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("t2_redirect_pc", {16'd0, redirect_pc}, 32'h0022);
        chk("t2_mispred", {16'd0, stat_mispred}, 32'd1);
        idle(1);
        chk("t2_pulse_end", {31'd0, redirect_valid}, 32'd0);

        // Target mispredict, then wrap of the fall-through PC, back-to-back
        send(16'h0030, 1'b1, 16'h0200, 1'b1, 16'h0100);
        chk("t3_redirect_pc", {16'd0, redirect_pc}, 32'h0200);
        send(16'hFFFE, 1'b0, 16'h0000, 1'b1, 16'h0000);
        chk("t3_wrap_valid", {31'd0, redirect_valid}, 32'd1);
        chk("t3_wrap_pc", {16'd0, redirect_pc}, 32'h0000);
        idle(3);

        // Fill under hold, try a fifth, then release
        upd_hold = 1'b1;
        for (int i = 0; i < 4; i++) send(16'(16'h0100 + 16'(i * 4)), 1'b0, 16'h0000, 1'b0, 16'h0000);
        chk("full_ready", {31'd0, res_ready}, 32'd0);
        res_valid = 1'b1; res_pc = 16'h0500;
        repeat (3) begin
            step();
            chk("full_blocked", {31'd0, res_ready}, 32'd0);
        end
        res_valid = 1'b0;
        base = upd_seen;
        upd_hold = 1'b0;
        repeat (4) step();
        chk("release_count", 32'(upd_seen - base), 32'd4);
        chk("release_ready", {31'd0, res_ready}, 32'd1);
        idle(2);

        // Streaming: 20 accepts with continuous drain
        base = upd_seen;
        for (int i = 0; i < 20; i++) send_rand();
        idle(2);
        chk("stream_count", 32'(upd_seen - base), 32'd20);

        // Reset with two entries queued
        upd_hold = 1'b1;
        send_rand();
        send_rand();
        rst = 1'b1; upd_hold = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
        chk("rst_ready", {31'd0, res_ready}, 32'd1);
        chk("rst_branches", {16'd0, stat_branches}, 32'd0);
        chk("rst_mispred", {16'd0, stat_mispred}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);

        // Randomized traffic with random drain stalls
        rand_hold = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send_rand();
        end
        rand_hold = 0;
        upd_hold  = 1'b0;
        idle(8);

        // Saturation and clear priority
        verbose = 0;
        for (int i = 0; i < 65536; i++) send_rand();
        chk("sat_branches", {16'd0, stat_branches}, 32'h0000FFFF);
        send_rand();
        chk("sat_hold", {16'd0, stat_branches}, 32'h0000FFFF);
        stat_clear = 1'b1;
        send_rand();
        stat_clear = 1'b0;
        chk("clear_branches", {16'd0, stat_branches}, 32'd0);
        chk("clear_mispred", {16'd0, stat_mispred}, 32'd0);
        verbose = 1;
        idle(8);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Sequences branch resolutions from the execute stage into the branch predictor's single update port. Each resolution is checked for misprediction; a registered redirect goes to fetch, and the resolution is buffered in a small FIFO that drains one entry per cycle into the predictor. The block also keeps saturating branch and mispredict counters for performance monitoring. It sits between the execute stage, the fetch PC mux and the predictor's update port.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- AW, 2: log2(DEPTH).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  execute stage presents a resolved branch.
- res_ready  out  1  FIFO can accept; equals (count != DEPTH).
- res_pc  in  16  PC of the branch.
- res_taken  in  1  actual direction.
- res_target  in  16  actual taken target.
- res_pred_taken  in  1  direction predicted at fetch.
- res_pred_target  in  16  target predicted at fetch.
- upd_hold  in  1  blocks draining this cycle.
- upd_en  out  1  update strobe to the predictor.
- upd_pc  out  16  FIFO head PC.
- upd_taken  out  1  FIFO head direction.
- upd_target  out  16  FIFO head target.
- redirect_valid  out  1  one-cycle mispredict redirect pulse.
- redirect_pc  out  16  correct next PC.
- stat_clear  in  1  zero both counters.
- stat_branches  out  16  accepted resolutions, saturating.
- stat_mispred  out  16  accepted mispredicts, saturating.

## Operation
- Accept a resolution when res_valid and res_ready are both 1. Resolutions with res_valid=1 and res_ready=0 are not accepted and cause no side effects; execute holds them.
- Mispredict, evaluated on accept: (res_taken != res_pred_taken) OR (res_taken AND res_pred_target != res_target).
- Correct PC: res_target if taken, otherwise res_pc + 16'd2 (mod 2^16; 16'hFFFE wraps to 16'h0000).
- Accepted resolution: write {pc, taken, target} to the FIFO at wr_ptr. Every accepted branch is enqueued, whether taken or not and whether mispredicted or not.
- Drain: upd_en = (count != 0) AND NOT upd_hold. upd_pc, upd_taken and upd_target come combinationally from the head entry. When upd_en=1, rd_ptr advances at the clock edge.
- Pointers are AW bits wide and wrap naturally. count is AW+1 bits.
- Push and pop in the same cycle leave count unchanged. Push at full is impossible because res_ready=0.
- Pop at empty is impossible because upd_en=0. upd_* values are don't-care while upd_en=0.
- Counters:
  - stat_branches increments on every accept.
  - stat_mispred increments on every accepted mispredict.
  - Both saturate at 16'hFFFF.
  - stat_clear has priority over a same-cycle increment; the counter reads 0 the next cycle.
- In-flight FIFO entries survive redirects. They are committed architectural outcomes and must not be flushed.

## Timing
- Reset values: count=0, pointers=0, res_ready=1, upd_en=0, redirect_valid=0, redirect_pc=16'h0000, both stats=0.
- Reset mid-operation discards all FIFO contents and any pending redirect. Nothing drains in the cycle after reset.
- Redirect latency:
  - Accept in cycle N gives redirect_valid=1 with redirect_pc in cycle N+1 (registered).
  - redirect_valid deasserts in N+2 unless another mispredict is accepted in N+1.
  - Back-to-back mispredicts produce back-to-back pulses.
- Update latency: an entry accepted in cycle N can appear with upd_en=1 no earlier than N+1. There is no FIFO bypass.
- Throughput: one accept and one drain per cycle, sustained.
- res_ready reflects registered count. A drain in the same cycle does not raise res_ready within that cycle.
- upd_hold=1 freezes the head. The head entry stays stable until the first cycle with upd_hold=0.
- Predictor update ordering equals acceptance order.

## Test plan
- Reset, then accept pc=16'h0010, taken=1, target=16'h0040, pred_taken=1, pred_target=16'h0040:
  - No redirect.
  - Next cycle: upd_en=1, upd_pc=16'h0010, upd_target=16'h0040.
  - stat_branches=1, stat_mispred=0.
- Accept pc=16'h0020, taken=0, pred_taken=1:
  - Next cycle: redirect_valid=1, redirect_pc=16'h0022 for exactly one cycle.
  - stat_mispred=1.
- Accept taken=1, pred_taken=1, pred_target=16'h0100, target=16'h0200:
  - redirect_pc=16'h0200.
  - Same scenario with pc=16'hFFFE, taken=0, pred_taken=1: redirect_pc=16'h0000.
- Hold upd_hold=1 and accept 4 branches back-to-back:
  - res_ready=0 after the 4th; a 5th res_valid is not accepted.
  - Release hold: 4 upd_en cycles in acceptance order, then res_ready=1.
- Run continuous res_valid with upd_hold=0 for 20 cycles: count stays ≤1 and there are 20 ordered updates. Then:
  - Assert rst with 2 entries queued: the next cycle shows upd_en=0, count=0 and both stats 0.
- Preload stat_branches to 16'hFFFF via 65535 accepts and accept one more: the counter stays at 16'hFFFF. Then:
  - Assert stat_clear together with an accept: the counter reads 0 next cycle.
